// File: rtl/if_prefetch_buf.sv
// Instruction-fetch stage: own PC, decoupled in-order ROM request/response, DEPTH-entry prefetch FIFO.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/flush performance counters.
module if_prefetch_buf #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter logic [XLEN-1:0] NOP_INST   = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_en_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            hold_flag_i,
  output logic            rom_req_o,
  output logic [XLEN-1:0] rom_addr_o,
  input  logic            rom_rvalid_i,
  input  logic [XLEN-1:0] rom_rdata_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_addr_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_o,
  output logic [31:0]     perf_flush_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_reg;
  logic [CW-1:0]   occ_reg;
  logic [CW-1:0]   out_reg;
  logic [CW-1:0]   discard_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   tag_rd_reg;
  logic [PW-1:0]   tag_wr_reg;
  logic            started_reg;

  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [XLEN-1:0] fifo_addr [DEPTH];
  logic [XLEN-1:0] tag_mem   [DEPTH];

  logic [CW:0]     credit_used;
  logic            issue;
  logic            resp;
  logic            push;
  logic            pop;
  logic [CW-1:0]   out_next;

  // Credits cover both buffered words and words still in flight, so the FIFO can never overflow.
  assign credit_used = {1'b0, occ_reg} + {1'b0, out_reg};
  assign issue       = started_reg && !jump_en_i && (credit_used < (CW+1)'(DEPTH));
  assign resp        = rom_rvalid_i && (out_reg != '0);
  assign push        = resp && (discard_reg == '0) && !jump_en_i;
  assign pop         = (occ_reg != '0) && !hold_flag_i && !jump_en_i;
  assign out_next    = out_reg + CW'(issue) - CW'(resp);

  assign rom_req_o    = issue;
  assign rom_addr_o   = pc_reg;
  assign inst_valid_o = (occ_reg != '0);
  assign inst_o       = inst_valid_o ? fifo_data[rd_ptr_reg] : NOP_INST;
  assign inst_addr_o  = inst_valid_o ? fifo_addr[rd_ptr_reg] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg      <= RESET_ADDR;
      occ_reg     <= '0;
      out_reg     <= '0;
      discard_reg <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      tag_rd_reg  <= '0;
      tag_wr_reg  <= '0;
      started_reg <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      out_reg     <= out_next;
      if (jump_en_i) begin
        // Everything still in flight belongs to the old path and must be dropped on arrival.
        pc_reg      <= jump_addr_i & ~XLEN'(3);
        occ_reg     <= '0;
        rd_ptr_reg  <= '0;
        wr_ptr_reg  <= '0;
        tag_rd_reg  <= '0;
        tag_wr_reg  <= '0;
        discard_reg <= out_reg - CW'(resp);
      end else begin
        if (issue) begin
          pc_reg     <= pc_reg + XLEN'(4);
          tag_wr_reg <= tag_wr_reg + PW'(1);
        end
        if (resp && (discard_reg != '0))
          discard_reg <= discard_reg - CW'(1);
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
          tag_rd_reg <= tag_rd_reg + PW'(1);
        end
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + PW'(1);
        occ_reg <= occ_reg + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue)
      tag_mem[tag_wr_reg] <= pc_reg;
    if (push) begin
      fifo_data[wr_ptr_reg] <= rom_rdata_i;
      fifo_addr[wr_ptr_reg] <= tag_mem[tag_rd_reg];
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_reg;
  logic [31:0] perf_flush_reg;
  logic [CW:0] flush_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // A flush counts cleared FIFO entries plus every response thrown away because of a redirect.
  assign flush_inc = (jump_en_i ? {1'b0, occ_reg} : '0)
                   + (CW+1)'(resp && ((discard_reg != '0) || jump_en_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_reg <= '0;
      perf_flush_reg <= '0;
    end else begin
      perf_fetch_reg <= sat_add(perf_fetch_reg, (CW+1)'(pop));
      perf_flush_reg <= sat_add(perf_flush_reg, flush_inc);
    end
  end

  assign perf_fetch_o = perf_fetch_reg;
  assign perf_flush_o = perf_flush_reg;
`endif

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Directed bench for if_prefetch_buf: ROM model returns the request address as data with selectable latency.
module tb_if_prefetch_buf;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        hold = 1'b0;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic        rom_rvalid;
  logic [31:0] rom_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
`endif

  int          checks = 0;
  int          errors = 0;
  int          lat = 1;
  int          cnt;
  logic [31:0] exp_addr;
  logic        stray = 1'b0;
  logic [31:0] stray_data = 32'hDEADBEEF;
  logic [3:0]  pv = '0;
  logic [31:0] pd [4];

  if_prefetch_buf dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .hold_flag_i  (hold),
    .rom_req_o    (rom_req),
    .rom_addr_o   (rom_addr),
    .rom_rvalid_i (rom_rvalid),
    .rom_rdata_i  (rom_rdata),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_o (perf_fetch),
    .perf_flush_o (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  // In-order ROM: a request accepted on one edge answers lat cycles later.
  always @(posedge clk) begin
    pv    <= {pv[2:0], rom_req};
    pd[0] <= rom_addr;
    pd[1] <= pd[0];
    pd[2] <= pd[1];
    pd[3] <= pd[2];
  end
  assign rom_rvalid = stray | pv[lat-1];
  assign rom_rdata  = stray ? stray_data : pd[lat-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
      chk({tag, "_addr"}, inst_addr, exp_addr);
      chk({tag, "_inst"}, inst, exp_addr);
      exp_addr = exp_addr + 32'd4;
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_addr", inst_addr, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf_fetch", perf_fetch, 32'd0);
    chk("rst_perf_flush", perf_flush, 32'd0);
`endif
    // Cycle 0..2 after release: first request one cycle later, first instruction at cycle 3
    @(negedge clk); rst = 1'b0; #1;
    chk("c0_req", 32'(rom_req), 32'd0);
    chk("c0_valid", 32'(inst_valid), 32'd0);
    @(negedge clk); #1;
    chk("c1_req", 32'(rom_req), 32'd1);
    chk("c1_rom_addr", rom_addr, 32'd0);
    chk("c1_valid", 32'(inst_valid), 32'd0);
    @(negedge clk); #1;
    chk("c2_rom_addr", rom_addr, 32'd4);
    chk("c2_valid", 32'(inst_valid), 32'd0);
    exp_addr = 32'd0;
    expect_stream("stream", 10);

    // Hold for 10 cycles: head stays at 40, FIFO fills and issue stops
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); hold = 1'b1;
      if (i == 7) lat = 3;
      #1;
      chk("hold_valid", 32'(inst_valid), 32'd1);
      chk("hold_addr", inst_addr, 32'd40);
    end
    chk("hold_full_req", 32'(rom_req), 32'd0);

    // Release two entries, re-hold, then jump with 2 in flight (3-cycle ROM)
    @(negedge clk); hold = 1'b0; #1;
    chk("rel_addr0", inst_addr, 32'd40);
    chk("rel_req0", 32'(rom_req), 32'd0);
    @(negedge clk); #1;
    chk("rel_addr1", inst_addr, 32'd44);
    chk("rel_rom_addr1", rom_addr, 32'd56);
    @(negedge clk); hold = 1'b1; #1;
    chk("rel_addr2", inst_addr, 32'd48);
    chk("rel_rom_addr2", rom_addr, 32'd60);
    @(negedge clk); jump_en = 1'b1; jump_addr = 32'h103; #1;
    chk("jmp_valid", 32'(inst_valid), 32'd1);
    chk("jmp_addr", inst_addr, 32'd48);
    chk("jmp_req", 32'(rom_req), 32'd0);
    @(negedge clk); jump_en = 1'b0; hold = 1'b0; #1;
    chk("jmp1_valid", 32'(inst_valid), 32'd0);
    chk("jmp1_inst", inst, NOP);
    chk("jmp1_addr", inst_addr, 32'd0);
    chk("jmp1_req", 32'(rom_req), 32'd1);
    chk("jmp1_rom_addr", rom_addr, 32'h100);
    @(negedge clk); #1;
    chk("jmp2_valid", 32'(inst_valid), 32'd0);
    chk("jmp2_rom_addr", rom_addr, 32'h104);
    @(negedge clk); #1;
    chk("jmp3_valid", 32'(inst_valid), 32'd0);
    chk("jmp3_rom_addr", rom_addr, 32'h108);
    @(negedge clk); #1;
    chk("jmp4_valid", 32'(inst_valid), 32'd0);
    chk("jmp4_rom_addr", rom_addr, 32'h10C);
    @(negedge clk); #1;
    chk("jmp5_valid", 32'(inst_valid), 32'd1);
    chk("jmp5_addr", inst_addr, 32'h100);
    chk("jmp5_credit_req", 32'(rom_req), 32'd0);

    // Sustained streaming with 3-cycle ROM: strictly sequential, four of every five cycles
    exp_addr = 32'h104;
    cnt = 1;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk); #1;
      if (inst_valid) begin
        chk("lat3_addr", inst_addr, exp_addr);
        chk("lat3_inst", inst, exp_addr);
        exp_addr = exp_addr + 32'd4;
        cnt++;
      end
    end
    checks++;
    assert (cnt >= 15)
    else begin
      errors++;
      $error("FAIL lat3_throughput observed=%0d expected>=%0d", cnt, 15);
    end

    // Drain the 3-cycle ROM under hold, switch to 1-cycle ROM
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); hold = 1'b1;
      if (i == 10) lat = 1;
      #1;
      chk("drain_addr", inst_addr, exp_addr);
    end
    chk("drain_req", 32'(rom_req), 32'd0);

    // Jump coinciding with a response and a consume
    @(negedge clk); hold = 1'b0; #1;
    chk("jc_addr0", inst_addr, exp_addr);
    @(negedge clk); #1;
    chk("jc_addr1", inst_addr, exp_addr + 32'd4);
    chk("jc_rom_addr1", rom_addr, exp_addr + 32'd16);
    @(negedge clk); jump_en = 1'b1; jump_addr = 32'h200; #1;
    chk("jc_valid2", 32'(inst_valid), 32'd1);
    chk("jc_addr2", inst_addr, exp_addr + 32'd8);
    chk("jc_rvalid_req", 32'(rom_req), 32'd0);
    @(negedge clk); jump_en = 1'b0; #1;
    chk("jc_empty", 32'(inst_valid), 32'd0);
    chk("jc_rom_addr3", rom_addr, 32'h200);
    @(negedge clk); #1;
    chk("jc_empty2", 32'(inst_valid), 32'd0);
    chk("jc_rom_addr4", rom_addr, 32'h204);
    exp_addr = 32'h200;
    expect_stream("jc_stream", 6);

    // Reset mid-stream, with a stray response after release
    @(negedge clk); rst = 1'b1; #1;
    chk("mrst_req", 32'(rom_req), 32'd0);
    chk("mrst_valid", 32'(inst_valid), 32'd0);
    chk("mrst_inst", inst, NOP);
    chk("mrst_addr", inst_addr, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("mrst_perf_fetch", perf_fetch, 32'd0);
    chk("mrst_perf_flush", perf_flush, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk); rst = 1'b0; stray = 1'b1; #1;
    chk("r0_req", 32'(rom_req), 32'd0);
    chk("r0_valid", 32'(inst_valid), 32'd0);
    @(negedge clk); #1;
    chk("r1_req", 32'(rom_req), 32'd1);
    chk("r1_rom_addr", rom_addr, 32'd0);
    chk("r1_valid", 32'(inst_valid), 32'd0);
    @(negedge clk); stray = 1'b0; #1;
    chk("r2_valid", 32'(inst_valid), 32'd0);
    chk("r2_rom_addr", rom_addr, 32'd4);
    exp_addr = 32'd0;
    expect_stream("r_stream", 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
